// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: latches a word via valid/ready and shifts it out MSB-first,
// replaying it a programmable number of times with idle gaps between replays.
module serial_pattern_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GAP      = 1,
  parameter bit          IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [3:0]       load_count,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  // Gap counter holds remaining idle cycles minus one, so GAP-1 must fit.
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]       reps_q, reps_d;
  logic [GW-1:0]    gapcnt_q, gapcnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    bitcnt_d      = bitcnt_q;
    reps_d        = reps_q;
    gapcnt_d      = gapcnt_q;
    ser_out_d     = IDLE_BIT;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A simultaneous abort is irrelevant here: loads win in IDLE.
        if (load_valid) begin
          word_d        = load_data;
          reps_d        = (load_count == 4'd0) ? 4'd1 : load_count;
          bitcnt_d      = BW'(WIDTH - 1);
          ser_out_d     = load_data[WIDTH-1];
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          state_d       = StShift;
        end
      end

      StShift: begin
        if (abort) begin
          state_d  = StIdle;
          bitcnt_d = '0;
          reps_d   = '0;
          gapcnt_d = '0;
        end else if (bitcnt_q != '0) begin
          bitcnt_d    = bitcnt_q - BW'(1);
          ser_out_d   = word_q[bitcnt_d];
          ser_valid_d = 1'b1;
        end else if (reps_q > 4'd1) begin
          reps_d = reps_q - 4'd1;
          if (GAP == 0) begin
            bitcnt_d      = BW'(WIDTH - 1);
            ser_out_d     = word_q[WIDTH-1];
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            state_d  = StGap;
            gapcnt_d = GW'(GAP - 1);
          end
        end else begin
          reps_d  = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      StGap: begin
        if (abort) begin
          state_d  = StIdle;
          bitcnt_d = '0;
          reps_d   = '0;
          gapcnt_d = '0;
        end else if (gapcnt_q == '0) begin
          state_d       = StShift;
          bitcnt_d      = BW'(WIDTH - 1);
          ser_out_d     = word_q[WIDTH-1];
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
        end else begin
          gapcnt_d = gapcnt_q - GW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      word_q        <= '0;
      bitcnt_q      <= '0;
      reps_q        <= '0;
      gapcnt_q      <= '0;
      ser_out_q     <= IDLE_BIT;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      bitcnt_q      <= bitcnt_d;
      reps_q        <= reps_d;
      gapcnt_q      <= gapcnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign load_ready  = (state_q == StIdle);
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: queue-based cycle model for the GAP=1 instance, plus directed
// literal expectations for both a GAP=1 and a GAP=0 instance.
module tb_serial_pattern_tx;

  localparam int W   = 8;
  localparam int G   = 1;
  localparam bit IB  = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data = '0;
  logic [3:0]   load_count = '0;
  logic         abort = 1'b0;
  logic         ser_out, ser_valid, frame_start, done;

  logic         v0 = 1'b0;
  logic         r0;
  logic [W-1:0] d0 = '0;
  logic [3:0]   c0 = '0;
  logic         a0 = 1'b0;
  logic         so0, sv0, fs0, dn0;

  serial_pattern_tx #(.WIDTH(W), .GAP(G), .IDLE_BIT(IB)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_count(load_count), .abort(abort), .ser_out(ser_out),
    .ser_valid(ser_valid), .frame_start(frame_start), .done(done)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP(0), .IDLE_BIT(IB)) dut0 (
    .clk(clk), .rst(rst), .load_valid(v0), .load_ready(r0),
    .load_data(d0), .load_count(c0), .abort(a0), .ser_out(so0),
    .ser_valid(sv0), .frame_start(fs0), .done(dn0)
  );

  always #5 clk = ~clk;

  // One entry per future cycle: what the outputs must show in that cycle.
  typedef struct packed {logic v; logic o; logic fs; logic d; logic rdy;} ent_t;
  ent_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic ent_t cur();
    if (q.size() > 0) return q[0];
    return '{v: 1'b0, o: IB, fs: 1'b0, d: 1'b0, rdy: 1'b1};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    ent_t e;
    int   reps;
    if (rst) begin
      q.delete();
    end else begin
      e = cur();
      if (e.rdy && load_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        reps = (load_count == 4'd0) ? 1 : int'(load_count);
        for (int r = 0; r < reps; r++) begin
          for (int i = W - 1; i >= 0; i--)
            q.push_back('{v: 1'b1, o: load_data[i], fs: (i == W - 1), d: 1'b0, rdy: 1'b0});
          if (r < reps - 1)
            for (int g = 0; g < G; g++)
              q.push_back('{v: 1'b0, o: IB, fs: 1'b0, d: 1'b0, rdy: 1'b0});
        end
        q.push_back('{v: 1'b0, o: IB, fs: 1'b0, d: 1'b1, rdy: 1'b1});
      end else if (!e.rdy && abort) begin
        q.delete();
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] data, input logic [3:0] count);
    int n;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = data;
    load_count = count;
    n = 0;
    while (!load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got=busy expected=ready");
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Samples cycles 1..n (cycle 1 is the current negedge), shifting in MSB-first.
  task automatic capture(input int n, input int abort_at, input int drop_at,
                         output logic [31:0] vs, output logic [31:0] os,
                         output logic [31:0] fss, output logic [31:0] ds,
                         output logic [31:0] rs);
    vs = '0; os = '0; fss = '0; ds = '0; rs = '0;
    for (int c = 1; c <= n; c++) begin
      vs  = {vs[30:0], ser_valid};
      os  = {os[30:0], ser_out};
      fss = {fss[30:0], frame_start};
      ds  = {ds[30:0], done};
      rs  = {rs[30:0], load_ready};
      abort = (c == abort_at);
      if (c == drop_at) load_valid = 1'b0;
      if (c < n) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] vs, os, fss, ds, rs;
    logic [7:0]  pat;
    int          fsn;
    int          n;

    fork
      begin : cmp
        ent_t e;
        forever begin
          @(negedge clk);
          e = cur();
          total++;
          if ({ser_valid, ser_out, frame_start, done, load_ready} !== e) begin
            bad++;
            $display("FAIL model_cycle @%0t: got v/o/fs/d/rdy=%b expected=%b", $time,
                     {ser_valid, ser_out, frame_start, done, load_ready}, e);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(load_ready), 32'd1);
    chk("reset_outs", 32'({ser_valid, ser_out, frame_start, done}), 32'd0);
    rst = 1'b0;

    // GAP=0 instance, count=3: 24 contiguous bits, frames at 1, 9, 17, done at 25
    @(negedge clk);
    v0 = 1'b1; d0 = 8'hB4; c0 = 4'd3;
    @(negedge clk);
    v0 = 1'b0;
    pat = 8'hB4;
    for (int c = 1; c <= 25; c++) begin
      chk($sformatf("gap0_c%0d", c), 32'({sv0, so0, fs0, dn0}),
          32'({(c <= 24), (c <= 24) ? pat[7 - ((c - 1) % 8)] : IB,
               (c == 1 || c == 9 || c == 17), (c == 25)}));
      if (c < 25) @(negedge clk);
    end

    // T1: single transmission
    send(8'hB4, 4'd1);
    capture(9, 0, 0, vs, os, fss, ds, rs);
    chk("t1_valid", vs, 32'h1FE);
    chk("t1_data", os, 32'h168);
    chk("t1_fs", fss, 32'h100);
    chk("t1_done", ds, 32'h001);
    chk("t1_ready", rs, 32'h001);

    // T2: two transmissions, one gap cycle
    send(8'hB4, 4'd2);
    capture(18, 0, 0, vs, os, fss, ds, rs);
    chk("t2_valid", vs, 32'h3FDFE);
    chk("t2_data", os, 32'h2D168);
    chk("t2_fs", fss, 32'h20100);
    chk("t2_done", ds, 32'h1);

    // T3: count=0 behaves as count=1
    send(8'hB4, 4'd0);
    capture(9, 0, 0, vs, os, fss, ds, rs);
    chk("t3_valid", vs, 32'h1FE);
    chk("t3_data", os, 32'h168);
    chk("t3_done", ds, 32'h001);

    // T4: load_valid held; second word taken in the done cycle
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'h81; load_count = 4'd1;
    @(negedge clk);
    load_data = 8'h7E;
    capture(18, 0, 10, vs, os, fss, ds, rs);
    chk("t4_valid", vs, 32'h3FDFE);
    chk("t4_data", os, 32'h204FC);
    chk("t4_fs", fss, 32'h20100);
    chk("t4_done", ds, 32'h201);
    chk("t4_ready", rs, 32'h201);

    // T5: abort during bit 4
    send(8'hB4, 4'd1);
    capture(12, 4, 0, vs, os, fss, ds, rs);
    chk("t5_valid", vs, 32'hF00);
    chk("t5_data", os, 32'hB00);
    chk("t5_done", ds, 32'h0);
    chk("t5_ready", rs, 32'h0FF);

    // abort together with a load in IDLE: load wins
    @(negedge clk);
    load_valid = 1'b1; abort = 1'b1; load_data = 8'hA5; load_count = 4'd1;
    @(negedge clk);
    load_valid = 1'b0; abort = 1'b0;
    capture(9, 0, 0, vs, os, fss, ds, rs);
    chk("t7_valid", vs, 32'h1FE);
    chk("t7_data", os, 32'h14A);
    chk("t7_done", ds, 32'h001);

    // count=15: fifteen frames, no wrap
    send(8'h5A, 4'd15);
    fsn = 0;
    n = 0;
    while (!done && n < 400) begin
      if (frame_start) fsn++;
      @(negedge clk);
      n++;
    end
    chk("c15_done_seen", 32'(done), 32'd1);
    chk("c15_frames", 32'(fsn), 32'd15);

    // T6: async reset in the gap
    send(8'hB4, 4'd2);
    repeat (8) @(negedge clk);
    chk("t6_in_gap", 32'({ser_valid, load_ready}), 32'd0);
    #2 rst = 1'b1;
    #1 chk("t6_async", 32'({load_ready, ser_valid, ser_out, frame_start, done}), 32'b10000);
    @(negedge clk);
    rst = 1'b0;
    send(8'h3C, 4'd1);
    capture(9, 0, 0, vs, os, fss, ds, rs);
    chk("t6_valid", vs, 32'h1FE);
    chk("t6_data", os, 32'h078);
    chk("t6_fs", fss, 32'h100);
    chk("t6_done", ds, 32'h001);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
